div_sequencer: RTL

//  Multi-cycle RV32M divide unit plus its control FSM, beside the ALU in the execute stage.

---
 rtl/div_sequencer.sv | 94 +++++++++
 1 files changed

// File: rtl/div_sequencer.sv
// div_sequencer: iterative RV32M divide unit with execute-stage stall control.
// Optional DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the iterations.
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_op1,
  input  logic [XLEN-1:0] req_op2,
  input  logic            kill,
  output logic            stall,
  output logic            busy,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_result
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] quo, rem, dvsr, dvnd, last, result, q_fix, r_fix, abs1, abs2;
  logic [1:0] op;
  logic neg_q, neg_r, dz, ovf;
  logic accept, req_signed, a_neg, b_neg, req_dz, req_ovf, early, ge;
  logic [XLEN:0] rem_sh, diff;
  assign req_signed = ~req_op[0];
  assign a_neg = req_signed & req_op1[XLEN-1];
  assign b_neg = req_signed & req_op2[XLEN-1];
  assign abs1 = a_neg ? -req_op1 : req_op1;
  assign abs2 = b_neg ? -req_op2 : req_op2;
  assign req_dz = req_op2 == '0;
  assign req_ovf = req_signed & (req_op1 == MIN_NEG) & (req_op2 == '1);
`ifdef DIV_EARLY_OUT_EN
  assign early = req_dz | req_ovf;
`else
  assign early = 1'b0;
`endif
  assign accept = (state == IDLE) & req_valid & ~kill;
  assign rem_sh = {rem, quo[XLEN-1]};
  assign diff = rem_sh - {1'b0, dvsr};
  assign ge = ~diff[XLEN];
  // Special cases bypass the iterated result so they hold regardless of early-out.
  assign q_fix = neg_q ? -quo : quo;
  assign r_fix = neg_r ? -rem : rem;
  assign result = dz ? (op[1] ? dvnd : '1) :
                  ovf ? (op[1] ? '0 : MIN_NEG) :
                  (op[1] ? r_fix : q_fix);
  always_comb begin
    state_n = kill ? IDLE :
              state == IDLE ? (req_valid ? (early ? DONE : BUSY) : IDLE) :
              state == BUSY ? (cnt == CNT_W'(1) ? DONE : BUSY) : IDLE;
    stall = accept | (state == BUSY);
    busy = state != IDLE;
    resp_valid = (state == DONE) & ~kill;
    resp_result = (state == DONE) ? result : last;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      quo <= '0;
      rem <= '0;
      dvsr <= '0;
      dvnd <= '0;
      last <= '0;
      op <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      ovf <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        op <= req_op;
        quo <= abs1;
        rem <= '0;
        dvsr <= abs2;
        dvnd <= req_op1;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        dz <= req_dz;
        ovf <= req_ovf;
        cnt <= CNT_W'(XLEN);
      end else if (state == BUSY) begin
        quo <= {quo[XLEN-2:0], ge};
        rem <= ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        cnt <= cnt - CNT_W'(1);
      end
      if (resp_valid) last <= result;
    end
  end
endmodule
